// File: rtl/data_sram_responder_if.sv
// rtl/data_sram_responder_if.sv - CPU data-port request/response bundle for the SRAM responder
interface data_sram_responder_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;

  modport master (output en, wen, addr, wdata, input rdata, stall);
  modport slave  (input en, wen, addr, wdata, output rdata, stall);
endinterface

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - fixed-latency word SRAM model answering CPU ME-stage loads/stores
module data_sram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  data_sram_responder_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q;
  logic [3:0]        wen_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              commit;
  logic [ADDR_W-1:0] acc_idx;
  logic [3:0]        acc_wen;
  logic [31:0]       acc_wdata;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};

  // cnt_q counts the stall cycles still owed, including the current one.
  // The accept cycle is itself a stall cycle, so with LATENCY==1 there is
  // no WAIT cycle and the access commits straight from the live inputs.
  assign accept    = (state_q == ST_IDLE) && bus.en;
  assign commit    = ((state_q == ST_WAIT) && (cnt_q == 4'd1)) || (accept && (LATENCY == 1));
  assign acc_idx   = accept ? bus.addr[ADDR_W+1:2] : idx_q;
  assign acc_wen   = accept ? bus.wen : wen_q;
  assign acc_wdata = accept ? bus.wdata : wdata_q;

  assign bus.stall = rst && (accept || (state_q == ST_WAIT));
  assign bus.rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          state_d = (LATENCY == 1) ? ST_DONE : ST_WAIT;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      ST_WAIT: begin
        if (commit) begin
          state_d = ST_DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wen_q   <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= bus.addr[ADDR_W+1:2];
        wen_q   <= bus.wen;
        wdata_q <= bus.wdata;
      end
      if (commit && (acc_wen == 4'd0)) begin
        rdata_q <= mem[acc_idx];
      end
    end
  end

  // RAM contents survive reset; only the commit edge writes
  always_ff @(posedge clk) begin
    if (commit && rst) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wen[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - randomized self-checking bench for data_sram_responder
module tb_data_sram_responder;
  localparam int ADDR_W = 10;
  localparam int LAT    = 2;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [31:0] mem_model [2**ADDR_W];
  logic [31:0] rd_model;

  data_sram_responder_if bus ();

  data_sram_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each access is one stall window of LAT cycles then one free
  // cycle; memory and rdata follow the byte-lane rules with wrap on word index.
  task automatic access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                        input bit scramble, input bit hold_en);
    int idx;
    logic [31:0] prev_rd;
    idx     = int'(a[ADDR_W+1:2]);
    prev_rd = rd_model;
    @(negedge clk);
    bus.en = 1'b1; bus.wen = w; bus.addr = a; bus.wdata = d;
    #1 check("stall_accept", 32'(bus.stall), 32'd1);
    if (w == 4'd0) begin
      rd_model = mem_model[idx];
    end else begin
      for (int b = 0; b < 4; b++)
        if (w[b]) mem_model[idx][8*b +: 8] = d[8*b +: 8];
    end
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      if (scramble) begin
        bus.wen = 4'($urandom); bus.addr = $urandom; bus.wdata = $urandom;
      end
      bus.en = hold_en ? 1'b1 : 1'($urandom);
      #1 check("stall_wait", 32'(bus.stall), 32'd1);
      check("rdata_wait_hold", bus.rdata, prev_rd);
    end
    @(negedge clk);
    bus.en = hold_en;
    if (!hold_en && scramble) bus.en = 1'($urandom);
    #1 check("stall_done", 32'(bus.stall), 32'd0);
    check("rdata_done", bus.rdata, rd_model);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.en = 1'b0; bus.wen = 4'($urandom); bus.addr = $urandom; bus.wdata = $urandom;
    #1 check("stall_idle", 32'(bus.stall), 32'd0);
    check("rdata_idle", bus.rdata, rd_model);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rd_model = 32'd0;
    rst      = 1'b0;
    bus.en = 1'b1; bus.wen = 4'd0; bus.addr = 32'd0; bus.wdata = 32'd0;
    repeat (2) @(negedge clk);
    #1 check("reset_stall", 32'(bus.stall), 32'd0);
    check("reset_rdata", bus.rdata, 32'd0);
    bus.en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle_cycle();

    for (int i = 0; i < 16; i++)
      access(4'hF, 32'(i * 4), $urandom, 1'b0, 1'b0);

    // store then load same word
    access(4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
    access(4'h0, 32'h10, 32'h0, 1'b0, 1'b0);
    check("t1_load", bus.rdata, 32'hDEADBEEF);
    // partial byte-lane store; rdata held across the store
    access(4'hF, 32'h10, 32'h11223344, 1'b0, 1'b0);
    access(4'b0010, 32'h10, 32'hAAAAAAAA, 1'b0, 1'b0);
    check("t2_rdata_held", bus.rdata, 32'hDEADBEEF);
    access(4'h0, 32'h10, 32'h0, 1'b0, 1'b0);
    check("t2_merge", bus.rdata, 32'h1122AA44);
    // back-to-back loads with en held continuously
    access(4'h0, 32'h4, 32'h0, 1'b0, 1'b1);
    access(4'h0, 32'h8, 32'h0, 1'b0, 1'b1);
    access(4'h0, 32'hC, 32'h0, 1'b0, 1'b1);
    idle_cycle();
    // inputs scrambled during WAIT
    access(4'b1001, 32'h14, 32'h9A00_00BC, 1'b1, 1'b0);
    access(4'h0, 32'h14, 32'h0, 1'b1, 1'b0);
    // wrap modulo DEPTH words
    access(4'hF, 32'h1000, 32'd7, 1'b0, 1'b0);
    access(4'h0, 32'h0000, 32'h0, 1'b0, 1'b0);
    check("t6_wrap", bus.rdata, 32'd7);

    // reset in the middle of a store: store must not commit
    access(4'hF, 32'h20, 32'hCAFEF00D, 1'b0, 1'b0);
    access(4'h0, 32'h20, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    bus.en = 1'b1; bus.wen = 4'hF; bus.addr = 32'h20; bus.wdata = 32'h55;
    #1 check("t5_stall_accept", 32'(bus.stall), 32'd1);
    @(negedge clk);
    bus.en = 1'b0;
    #1 rst = 1'b0;
    #1 check("t5_stall_rst", 32'(bus.stall), 32'd0);
    check("t5_rdata_rst", bus.rdata, 32'd0);
    rd_model = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    idle_cycle();
    access(4'h0, 32'h20, 32'h0, 1'b0, 1'b0);
    check("t5_old_contents", bus.rdata, 32'hCAFEF00D);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      logic [3:0]  w;
      a = $urandom;
      a[ADDR_W+1:2] = ADDR_W'($urandom_range(0, 15));
      w = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
      access(w, a, $urandom, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
